data_mem_responder: RTL

//   Memory-side responder for the core's load/store port: accepts one request at a time over a

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 31 +++
 rtl/data_mem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder FSM and its backing array.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = $clog2(16);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide data RAM: synchronous byte-strobe write, asynchronous read.
// Contents are deliberately left unreset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [STRB_W-1:0] strb_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request, fixed wait,
// response held until taken; flags misaligned/out-of-range addresses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] SPAN  = WORD_W'(4 * DEPTH_WORDS);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  req_t              req_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [WORD_W-1:0] offset;
  logic              addr_err;
  logic              do_access;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // Below-base addresses wrap to a huge offset and fail the range test.
  assign offset    = req_q.addr - BASE_ADDR;
  assign addr_err  = (req_q.addr[1:0] != 2'b00) || (offset >= SPAN);
  assign do_access = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we    = do_access && req_q.we && !addr_err && !rst;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .strb_i (req_q.wstrb),
    .idx_i  (offset[IDX_W+1:2]),
    .wdata_i(req_q.wdata),
    .rdata_o(mem_rdata)
  );

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q   <= '{we: req_we, addr: req_addr,
                         wdata: req_wdata, wstrb: req_wstrb};
            cnt_q   <= CNT_W'(LATENCY);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= addr_err;
            rsp_rdata_q <= (!addr_err && !req_q.we) ? mem_rdata : '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
